// File: rtl/bus_pkg.sv
// -----------------------------------------------------------------------------
// bus_pkg
// Shared definitions for the bus responder:
//   - HDR_DEFAULT  : default frame header value marking a valid bus word
//   - field bit positions inside the 32-bit command word
//   - opcode_e     : 3-bit opcode encoding
//   - state_e      : responder FSM state encoding
// -----------------------------------------------------------------------------
package bus_pkg;

    localparam logic [7:0] HDR_DEFAULT = 8'hAC;

    // Command word layout: [31:24] header, [23] tag, [22:20] opcode,
    // [19:14] reserved, [13:0] data.
    localparam int HDR_MSB  = 31;
    localparam int HDR_LSB  = 24;
    localparam int TAG_BIT  = 23;
    localparam int OP_MSB   = 22;
    localparam int OP_LSB   = 20;
    localparam int RSV_MSB  = 19;
    localparam int RSV_LSB  = 14;
    localparam int DATA_MSB = 13;
    localparam int DATA_W   = 14;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LDA  = 3'd1,
        OP_LDB  = 3'd2,
        OP_ADD  = 3'd3,
        OP_MUL  = 3'd4,
        OP_ACC  = 3'd5,
        OP_CLR  = 3'd6,
        OP_RSVD = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/mul4x4_seq.sv
// -----------------------------------------------------------------------------
// mul4x4_seq
// 4x4 unsigned shift-add multiplier, one partial product per clock.
//   clk     : system clock
//   rst     : synchronous, active-low reset
//   start   : request a multiply; only sampled while the unit is not running
//   a, b    : 4-bit operands, captured on the start edge
//   done    : high during the final cycle; product is valid while done is high
//   product : 8-bit product (a * b)
// Start at edge S: partial products for b[0], b[1], b[2] are accumulated at
// S, S+1, S+2; b[3] is added combinationally so the full product is visible
// in the cycle ending at S+3, giving a 4-edge operation where the consumer
// captures the product on the 4th edge.
// -----------------------------------------------------------------------------
module mul4x4_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       done,
    output logic [7:0] product
);

    logic       run_q,    run_d;
    logic [1:0] cnt_q,    cnt_d;
    logic [7:0] acc_q,    acc_d;
    logic [7:0] mcand_q,  mcand_d;
    logic [2:0] mplier_q, mplier_d;

    logic [7:0] partial;
    logic [7:0] sum;

    // Multiplier LSB selects the (already shifted) multiplicand.
    assign partial = mplier_q[0] ? mcand_q : 8'd0;
    assign sum     = acc_q + partial;

    assign done    = run_q && (cnt_q == 2'd3);
    assign product = sum;

    always_comb begin
        run_d    = run_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;

        if (!run_q) begin
            if (start) begin
                run_d    = 1'b1;
                cnt_d    = 2'd1;
                acc_d    = b[0] ? {4'd0, a} : 8'd0;
                mcand_d  = {3'd0, a, 1'b0};
                mplier_d = b[3:1];
            end
        end else if (cnt_q == 2'd3) begin
            // Last partial product is consumed this cycle via 'product'.
            run_d = 1'b0;
            cnt_d = 2'd0;
        end else begin
            acc_d    = sum;
            mcand_d  = {mcand_q[6:0], 1'b0};
            mplier_d = {1'b0, mplier_q[2:1]};
            cnt_d    = cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            run_q    <= 1'b0;
            cnt_q    <= 2'd0;
            acc_q    <= 8'd0;
            mcand_q  <= 8'd0;
            mplier_q <= 3'd0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/bus_responder.sv
// -----------------------------------------------------------------------------
// bus_responder
// Accepts tagged command frames from a CPU bus word, executes a small
// arithmetic opcode set and reports completion.
//   clk      : system clock, rising edge
//   rst      : synchronous, active-low reset
//   dataBus  : 32-bit command word (header, tag, opcode, reserved, data)
//   ack      : tag of the last completed frame
//   result   : 14-bit arithmetic result register
//   frameCnt : 7-bit wrapping count of completed frames
//   busy     : high from frame acceptance until completion
//   err      : sticky error flag (reserved opcode), cleared by CLR or reset
// A frame is accepted only in IDLE, only with the correct header and only
// when its tag differs from the last accepted tag, so a word held on the bus
// is executed once. Flow is IDLE -> EXEC (1 cycle, 4 for MUL) -> DONE -> IDLE.
// -----------------------------------------------------------------------------
module bus_responder
    import bus_pkg::*;
#(
    parameter logic [7:0] HDR = HDR_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       dataBus,
    output logic              ack,
    output logic [DATA_W-1:0] result,
    output logic [6:0]        frameCnt,
    output logic              busy,
    output logic              err
);

    state_e            state_q,     state_d;
    opcode_e           op_q,        op_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic              last_tag_q,  last_tag_d;
    logic              ack_q,       ack_d;
    logic [DATA_W-1:0] result_q,    result_d;
    logic [3:0]        op_a_q,      op_a_d;
    logic [3:0]        op_b_q,      op_b_d;
    logic [6:0]        frame_cnt_q, frame_cnt_d;
    logic              busy_q,      busy_d;
    logic              err_q,       err_d;

    logic       hdr_ok;
    logic       tag_new;
    logic [4:0] add_sum;
    logic       mul_start;
    logic       mul_done;
    logic [7:0] mul_product;
    logic       unused_rsvd;

    assign hdr_ok      = (dataBus[HDR_MSB:HDR_LSB] == HDR);
    assign tag_new     = (dataBus[TAG_BIT] != last_tag_q);
    assign add_sum     = {1'b0, op_a_q} + {1'b0, op_b_q};
    assign unused_rsvd = ^dataBus[RSV_MSB:RSV_LSB];

    // The multiplier ignores start while it is running, so holding start for
    // the whole MUL execution launches exactly one operation.
    mul4x4_seq u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (op_a_q),
        .b       (op_b_q),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        data_d      = data_q;
        last_tag_d  = last_tag_q;
        ack_d       = ack_q;
        result_d    = result_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        frame_cnt_d = frame_cnt_q;
        busy_d      = busy_q;
        err_d       = err_q;
        mul_start   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hdr_ok && tag_new) begin
                    op_d       = opcode_e'(dataBus[OP_MSB:OP_LSB]);
                    data_d     = dataBus[DATA_MSB:0];
                    last_tag_d = dataBus[TAG_BIT];
                    busy_d     = 1'b1;
                    state_d    = ST_EXEC;
                end
            end

            ST_EXEC: begin
                state_d = ST_DONE;
                case (op_q)
                    OP_NOP:  ;
                    OP_LDA:  op_a_d = data_q[3:0];
                    OP_LDB:  op_b_d = data_q[3:0];
                    OP_ADD:  result_d = {{(DATA_W-5){1'b0}}, add_sum};
                    OP_MUL: begin
                        mul_start = 1'b1;
                        if (mul_done) begin
                            result_d = {{(DATA_W-8){1'b0}}, mul_product};
                        end else begin
                            state_d = ST_EXEC;
                        end
                    end
                    OP_ACC:  result_d = result_q + data_q;   // wraps mod 2^14
                    OP_CLR: begin
                        result_d = '0;
                        err_d    = 1'b0;
                    end
                    OP_RSVD: err_d = 1'b1;
                    default: ;
                endcase
            end

            ST_DONE: begin
                ack_d       = last_tag_q;
                frame_cnt_d = frame_cnt_q + 7'd1;
                busy_d      = 1'b0;
                state_d     = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_NOP;
            data_q      <= '0;
            last_tag_q  <= 1'b0;
            ack_q       <= 1'b0;
            result_q    <= '0;
            op_a_q      <= 4'd0;
            op_b_q      <= 4'd0;
            frame_cnt_q <= 7'd0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            data_q      <= data_d;
            last_tag_q  <= last_tag_d;
            ack_q       <= ack_d;
            result_q    <= result_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign ack      = ack_q;
    assign result   = result_q;
    assign frameCnt = frame_cnt_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_bus_responder
// Self-checking bench for bus_responder: a directed vector table, hand-written
// timing/reset sequences, and randomized frames against a frame-level model.
// -----------------------------------------------------------------------------
module tb_bus_responder;

    logic        clk;
    logic        rst;
    logic [31:0] dataBus;
    logic        ack;
    logic [13:0] result;
    logic [6:0]  frameCnt;
    logic        busy;
    logic        err;

    int checks = 0;
    int errors = 0;

    bus_responder #(.HDR(8'hAC)) dut (
        .clk      (clk),
        .rst      (rst),
        .dataBus  (dataBus),
        .ack      (ack),
        .result   (result),
        .frameCnt (frameCnt),
        .busy     (busy),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        int          hold;
        int          res;
        int          ack;
        int          cnt;
        int          err;
    } vec_t;

    vec_t vecs[12];

    // Frame-level reference model state
    int m_last_tag, m_opa, m_opb, m_res, m_cnt, m_ack, m_err;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b0;
        dataBus = 32'h0;
        tick(2);
        rst = 1'b1;
        m_last_tag = 0; m_opa = 0; m_opb = 0; m_res = 0;
        m_cnt = 0; m_ack = 0; m_err = 0;
    endtask

    task automatic run_frame(input logic [31:0] w, input int hold);
        dataBus = w;
        tick(hold);
        dataBus = 32'h0;
    endtask

    task automatic model_frame(input logic [31:0] w);
        int d;
        if (w[31:24] == 8'hAC && int'(w[23]) != m_last_tag) begin
            m_last_tag = int'(w[23]);
            d = int'(w[13:0]);
            case (int'(w[22:20]))
                1: m_opa = d % 16;
                2: m_opb = d % 16;
                3: m_res = m_opa + m_opb;
                4: m_res = m_opa * m_opb;
                5: m_res = (m_res + d) % 16384;
                6: begin m_res = 0; m_err = 0; end
                7: m_err = 1;
                default: ;
            endcase
            m_ack = m_last_tag;
            m_cnt = (m_cnt + 1) % 128;
        end
    endtask

    task automatic check_outputs(input string tag, input int e_res, input int e_ack,
                                 input int e_cnt, input int e_err);
        check({tag, "_result"}, int'(result), e_res);
        check({tag, "_ack"}, int'(ack), e_ack);
        check({tag, "_frameCnt"}, int'(frameCnt), e_cnt);
        check({tag, "_err"}, int'(err), e_err);
        check({tag, "_busy"}, int'(busy), 0);
    endtask

    initial begin
        int busy_cycles;
        logic [31:0] w;
        logic [7:0]  hdr;

        vecs[0]  = '{32'hAC900003, 6,  0,      1, 1,  0};  // tag1 LDA 3
        vecs[1]  = '{32'hAC200005, 6,  0,      0, 2,  0};  // tag0 LDB 5
        vecs[2]  = '{32'hACB00000, 6,  8,      1, 3,  0};  // tag1 ADD
        vecs[3]  = '{32'hAC400000, 6,  15,     0, 4,  0};  // tag0 MUL
        vecs[4]  = '{32'hAC900007, 10, 15,     1, 5,  0};  // held 10 cycles
        vecs[5]  = '{32'hAB200007, 6,  15,     1, 5,  0};  // bad header
        vecs[6]  = '{32'hAC600000, 6,  0,      0, 6,  0};  // tag0 CLR
        vecs[7]  = '{32'hACD03FF0, 6,  16'h3FF0, 1, 7, 0}; // tag1 ACC 0x3FF0
        vecs[8]  = '{32'hAC500020, 6,  16'h0010, 0, 8, 0}; // tag0 ACC wraps
        vecs[9]  = '{32'hACF00000, 6,  16'h0010, 1, 9, 1}; // tag1 reserved
        vecs[10] = '{32'hAC600000, 6,  0,      0, 10, 0};  // tag0 CLR
        vecs[11] = '{32'hAC700000, 6,  0,      0, 10, 0};  // same tag ignored

        rst     = 1'b0;
        dataBus = 32'h0;

        // ---------------- reset state ----------------
        do_reset();
        check_outputs("reset", 0, 0, 0, 0);
        $display("reset: result=%0d ack=%0d cnt=%0d err=%0d", result, ack, frameCnt, err);

        // ---------------- directed table ----------------
        for (int i = 0; i < 12; i++) begin
            run_frame(vecs[i].word, vecs[i].hold);
            $display("vec %0d word=%h result=%h ack=%0d cnt=%0d err=%0d",
                     i, vecs[i].word, result, ack, frameCnt, err);
            check_outputs($sformatf("vec%0d", i), vecs[i].res, vecs[i].ack,
                          vecs[i].cnt, vecs[i].err);
        end

        // ---------------- MUL latency: busy 5 cycles, result E4, ack E5 ------
        do_reset();
        run_frame(32'hAC900003, 6);          // tag1 LDA 3
        run_frame(32'hAC200005, 6);          // tag0 LDB 5
        dataBus = 32'hACC00000;              // tag1 MUL
        busy_cycles = 0;
        for (int e = 0; e <= 5; e++) begin
            tick(1);                         // sample just after edge E<e>
            if (busy) busy_cycles++;
            if (e == 3) check("mul_result_E3", int'(result), 0);
            if (e == 4) begin
                check("mul_result_E4", int'(result), 15);
                check("mul_ack_E4", int'(ack), 0);
            end
            if (e == 5) begin
                check("mul_ack_E5", int'(ack), 1);
                check("mul_cnt_E5", int'(frameCnt), 3);
                check("mul_busy_E5", int'(busy), 0);
            end
        end
        check("mul_busy_cycles", busy_cycles, 5);
        $display("mul seq: result=%0d ack=%0d cnt=%0d busy_cycles=%0d",
                 result, ack, frameCnt, busy_cycles);

        // ---------------- 1-cycle latency, new frame waiting while busy ------
        dataBus = 32'hAC300000;              // tag0 ADD
        tick(1);                             // after E0
        check("add_busy_E0", int'(busy), 1);
        check("add_result_E0", int'(result), 15);
        dataBus = 32'hAC900009;              // tag1 LDA 9 presented while busy
        tick(1);                             // after E1
        check("add_result_E1", int'(result), 8);
        check("add_ack_E1", int'(ack), 1);
        tick(1);                             // after E2
        check("add_ack_E2", int'(ack), 0);
        check("add_busy_E2", int'(busy), 0);
        check("add_cnt_E2", int'(frameCnt), 4);
        tick(1);                             // after E3: pending frame taken
        check("pend_busy_E3", int'(busy), 1);
        tick(2);                             // after E5
        check("pend_cnt", int'(frameCnt), 5);
        check("pend_ack", int'(ack), 1);
        dataBus = 32'h0;
        $display("latency seq: result=%0d ack=%0d cnt=%0d", result, ack, frameCnt);

        // ---------------- reset during a MUL ----------------
        run_frame(32'hAC700000, 6);          // tag0 reserved -> err=1
        check("pre_rst_err", int'(err), 1);
        dataBus = 32'hACC00000;              // tag1 MUL
        tick(2);                             // after E1: in 2nd MUL cycle
        rst = 1'b0;
        tick(1);
        check_outputs("midmul_rst", 0, 0, 0, 0);
        rst = 1'b1;
        run_frame(32'hAC100009, 6);          // tag0: must be ignored
        check_outputs("post_rst_tag0", 0, 0, 0, 0);
        run_frame(32'hAC900009, 6);          // tag1: accepted
        check_outputs("post_rst_tag1", 0, 1, 1, 0);
        $display("reset seq: result=%0d ack=%0d cnt=%0d err=%0d", result, ack, frameCnt, err);

        // ---------------- randomized frames vs model ----------------
        do_reset();
        for (int i = 0; i < 400; i++) begin
            hdr = ($urandom_range(0, 99) < 85) ? 8'hAC : 8'($urandom);
            w = {hdr, 1'($urandom), 3'($urandom), 6'($urandom), 14'($urandom)};
            model_frame(w);
            run_frame(w, int'($urandom_range(6, 10)));
            $display("rnd %0d word=%h result=%h ack=%0d cnt=%0d err=%0d",
                     i, w, result, ack, frameCnt, err);
            check_outputs($sformatf("rnd%0d", i), m_res, m_ack, m_cnt, m_err);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_responder.md
BUS_RESPONDER -- requirements
Module: bus_responder

Interface
REQ-001 Parameter HDR, default 8'hAC, is the frame header value that marks a valid bus word.
REQ-002 Port clk, input, 1: system clock; all state updates on rising edge.
REQ-003 Port rst, input, 1: reset, synchronous, active-low.
REQ-004 Port dataBus, input, 32: command word from the CPU; [31:24] header, [23] tag, [22:20] opcode, [19:14] reserved (ignored), [13:0] data.
REQ-005 Port ack, output, 1: echo of the tag of the last completed frame.
REQ-006 Port result, output, 14: arithmetic result register.
REQ-007 Port frameCnt, output, 7: count of completed frames.
REQ-008 Port busy, output, 1: high while a frame is being executed.
REQ-009 Port err, output, 1: sticky error flag.

Function
REQ-010 FSM states SHALL be IDLE, EXEC and DONE; IDLE is the only state that samples dataBus.
REQ-011 In IDLE, a frame SHALL be accepted when dataBus[31:24]==HDR and dataBus[23]!=lastTag; on accept: latch opcode and data, lastTag<=dataBus[23], busy<=1, go to EXEC.
REQ-012 Header mismatch or tag==lastTag SHALL be ignored silently (no state change, no err).
REQ-013 Opcode 0 NOP: no register change; EXEC lasts 1 cycle.
REQ-014 Opcode 1 LDA: opA<=data[3:0]; 1 cycle.
REQ-015 Opcode 2 LDB: opB<=data[3:0]; 1 cycle.
REQ-016 Opcode 3 ADD: result<=zero-extended opA+opB (max 30); 1 cycle.
REQ-017 Opcode 4 MUL: result<=opA*opB (max 225) by sequential shift-add; EXEC lasts exactly 4 cycles; result written on the 4th.
REQ-018 Opcode 5 ACC: result<=(result+data) mod 2^14, wrap with no flag; 1 cycle.
REQ-019 Opcode 6 CLR: result<=0 and err<=0; 1 cycle.
REQ-020 Opcode 7 reserved: err<=1, result unchanged; 1 cycle.
REQ-021 From EXEC the FSM SHALL enter DONE, where ack<=lastTag, frameCnt<=frameCnt+1 (127 wraps to 0), busy<=0, and it returns to IDLE on the next edge.
REQ-022 Latency: frame accepted at edge E0; a 1-cycle op writes result at E1 and ack at E2; MUL writes result at E4 and ack at E5; next acceptance is possible no earlier than edge E3 (1-cycle op) or E6 (MUL).
REQ-023 A new-tag frame present while busy SHALL NOT be sampled; it is accepted in the first IDLE cycle if it is still present.
REQ-024 frameCnt SHALL count every completed frame, including NOP and reserved opcodes.
REQ-025 err SHALL be cleared only by CLR or reset.

Reset
REQ-026 When rst==0 at a clock edge: state=IDLE; ack=0; lastTag=0; result=0; opA=opB=0; frameCnt=0; busy=0; err=0.
REQ-027 Reset asserted mid-EXEC (including a partial MUL) SHALL abort the frame with no ack and no frameCnt increment.
REQ-028 After reset, the first frame SHALL carry tag=1 to be accepted.

Structure
REQ-029 Shared package bus_pkg SHALL hold HDR default, opcode constants, dataBus field bit positions and the FSM state encoding.
REQ-030 The sequential multiplier SHALL be sub-module mul4x4_seq (start, 4-bit a/b, done, 8-bit product, 4-cycle shift-add).
REQ-031 The top level SHALL contain only the FSM, decode, and registers.

Verification
REQ-032 Reset then 0xAC900003 (tag1, LDA 3), 0xAC200005 (tag0, LDB 5), 0xACB00000 (tag1, ADD) -> result=8, ack=1, frameCnt=3.
REQ-033 After REQ-032, 0xAC400000 (tag0, MUL) -> busy high 5 cycles, result=15 at E4, ack=0 at E5, frameCnt=4.
REQ-034 Hold 0xAC900007 for 10 cycles -> accepted once only, frameCnt +1; then 0xAB200007 (bad header) -> ignored.
REQ-035 result=0x3FF0, then ACC frame with data 0x0020 -> result=0x0010 (wrap); opcode 7 frame -> err=1; CLR -> err=0, result=0.
REQ-036 Assert rst at the 2nd cycle of a MUL -> all outputs at reset values; next tag-0 frame ignored; next tag-1 frame accepted.
